// File: rtl/pulse_width_meter.sv
// Measures the high width of a monitored signal from its rise/fall event pulses
// and queues one {width, saturated} record per completed pulse in a 2-entry FIFO.
module pulse_width_meter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rise_i,
    input  logic             fall_i,
    input  logic             clr_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_width,
    output logic             out_sat,
    output logic             busy_o,
    output logic             overrun_o,
    output logic             err_o
);

    // Handshake: a record transfers on any rising edge where out_valid && out_ready.
    // out_valid/out_width/out_sat come only from registers, never from out_ready,
    // and hold steady from the moment out_valid rises until the record is taken.

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic             sat;

    logic             push;
    logic             proto_err;

    logic [WIDTH-1:0] fifo_width [2];
    logic             fifo_sat   [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       fifo_cnt;

    logic             pop;
    logic             fifo_full;
    logic             push_ok;
    logic             push_drop;

    // Event decode: which events complete a record and which are protocol faults.
    always_comb begin
        push      = 1'b0;
        proto_err = 1'b0;
        case (state)
            IDLE: begin
                if (rise_i && fall_i) proto_err = 1'b1;
            end
            MEASURE: begin
                if (fall_i) push = 1'b1;
                if (rise_i && !fall_i) proto_err = 1'b1;
            end
            default: begin
                push      = 1'b0;
                proto_err = 1'b0;
            end
        endcase
    end

    assign pop       = out_valid && out_ready;
    assign fifo_full = (fifo_cnt == 2'd2);
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign push_ok   = push && (!fifo_full || pop);
    assign push_drop = push && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            sat   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise_i && !fall_i) begin
                        state <= MEASURE;
                        cnt   <= CNT_ONE;
                        sat   <= 1'b0;
                    end
                end
                MEASURE: begin
                    if (rise_i) begin
                        // Either a lost pulse or fall-then-rise: both restart the count.
                        cnt <= CNT_ONE;
                        sat <= 1'b0;
                    end else if (fall_i) begin
                        state <= IDLE;
                        cnt   <= '0;
                        sat   <= 1'b0;
                    end else if (cnt == CNT_MAX) begin
                        sat <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    sat   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            if (push_ok) begin
                fifo_width[wr_ptr] <= cnt;
                fifo_sat[wr_ptr]   <= sat;
                wr_ptr             <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push_ok, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Sticky status: a new event in the same cycle as clr_i takes priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_o <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            overrun_o <= push_drop | (overrun_o & ~clr_i);
            err_o     <= proto_err | (err_o & ~clr_i);
        end
    end

    assign busy_o    = (state == MEASURE);
    assign out_valid = (fifo_cnt != 2'd0);
    assign out_width = out_valid ? fifo_width[rd_ptr] : '0;
    assign out_sat   = out_valid ? fifo_sat[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_pulse_width_meter.sv
// Directed bench for pulse_width_meter: a WIDTH=16 instance for general behaviour
// and a WIDTH=4 instance sharing the same stimulus for saturation.
module tb_pulse_width_meter;

    logic clk;
    logic rst;
    logic rise_i;
    logic fall_i;
    logic clr_i;
    logic out_ready;

    logic        out_valid;
    logic [15:0] out_width;
    logic        out_sat;
    logic        busy_o;
    logic        overrun_o;
    logic        err_o;

    logic        out_valid4;
    logic [3:0]  out_width4;
    logic        out_sat4;
    logic        busy4;
    logic        overrun4;
    logic        err4;

    int n_vec;
    int n_bad;

    pulse_width_meter #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .rise_i(rise_i), .fall_i(fall_i), .clr_i(clr_i),
        .out_valid(out_valid), .out_ready(out_ready), .out_width(out_width),
        .out_sat(out_sat), .busy_o(busy_o), .overrun_o(overrun_o), .err_o(err_o)
    );

    pulse_width_meter #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .rise_i(rise_i), .fall_i(fall_i), .clr_i(clr_i),
        .out_valid(out_valid4), .out_ready(out_ready), .out_width(out_width4),
        .out_sat(out_sat4), .busy_o(busy4), .overrun_o(overrun4), .err_o(err4)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Rise sampled at edge E0, fall sampled at edge E0+n.
    task automatic pulse(input int n);
        rise_i = 1'b1;
        tick();
        rise_i = 1'b0;
        repeat (n - 1) tick();
        fall_i = 1'b1;
        tick();
        fall_i = 1'b0;
    endtask

    initial begin
        n_vec     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        rise_i    = 1'b0;
        fall_i    = 1'b0;
        clr_i     = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_valid",   32'(out_valid), 0);
        check("rst_width",   32'(out_width), 0);
        check("rst_sat",     32'(out_sat), 0);
        check("rst_busy",    32'(busy_o), 0);
        check("rst_overrun", 32'(overrun_o), 0);
        check("rst_err",     32'(err_o), 0);

        // fall alone in IDLE is ignored
        fall_i = 1'b1;
        tick();
        fall_i = 1'b0;
        check("idle_fall_valid", 32'(out_valid), 0);
        check("idle_fall_busy",  32'(busy_o), 0);

        // basic width 12, ready held high: valid for exactly one cycle
        out_ready = 1'b1;
        rise_i = 1'b1;
        tick();
        rise_i = 1'b0;
        check("basic_busy_up", 32'(busy_o), 1);
        repeat (11) tick();
        fall_i = 1'b1;
        tick();
        fall_i = 1'b0;
        check("basic_valid", 32'(out_valid), 1);
        check("basic_width", 32'(out_width), 12);
        check("basic_sat",   32'(out_sat), 0);
        check("basic_busy_dn", 32'(busy_o), 0);
        tick();
        check("basic_valid_gone", 32'(out_valid), 0);
        check("basic_width_zero", 32'(out_width), 0);

        // saturation on the 4-bit instance
        pulse(20);
        check("sat20_w4",   32'(out_width4), 15);
        check("sat20_s4",   32'(out_sat4), 1);
        check("sat20_w16",  32'(out_width), 20);
        check("sat20_s16",  32'(out_sat), 0);
        tick();
        pulse(15);
        check("edge15_w4", 32'(out_width4), 15);
        check("edge15_s4", 32'(out_sat4), 0);
        tick();
        pulse(16);
        check("edge16_w4", 32'(out_width4), 15);
        check("edge16_s4", 32'(out_sat4), 1);
        tick();

        // backpressure and overrun
        out_ready = 1'b0;
        pulse(3);
        tick();
        pulse(5);
        tick();
        pulse(7);
        check("bp_overrun", 32'(overrun_o), 1);
        check("bp_valid",   32'(out_valid), 1);
        check("bp_head3",   32'(out_width), 3);
        tick();
        check("bp_hold3",   32'(out_width), 3);
        out_ready = 1'b1;
        tick();
        check("bp_head5",   32'(out_width), 5);
        tick();
        check("bp_empty",   32'(out_valid), 0);
        check("bp_ovr_kept", 32'(overrun_o), 1);
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        check("bp_ovr_clr", 32'(overrun_o), 0);

        // full FIFO with pop in the same cycle as a push
        out_ready = 1'b0;
        pulse(4);
        tick();
        pulse(6);
        check("fpp_head4", 32'(out_width), 4);
        rise_i = 1'b1;
        tick();
        rise_i = 1'b0;
        tick();
        fall_i    = 1'b1;
        out_ready = 1'b1;
        tick();
        fall_i = 1'b0;
        check("fpp_no_ovr", 32'(overrun_o), 0);
        check("fpp_head6",  32'(out_width), 6);
        tick();
        check("fpp_head2",  32'(out_width), 2);
        tick();
        check("fpp_empty",  32'(out_valid), 0);

        // rise while measuring: first pulse lost, error flagged
        rise_i = 1'b1;
        tick();
        rise_i = 1'b0;
        repeat (4) tick();
        rise_i = 1'b1;
        tick();
        rise_i = 1'b0;
        check("rr_err",  32'(err_o), 1);
        check("rr_busy", 32'(busy_o), 1);
        check("rr_no_rec", 32'(out_valid), 0);
        repeat (3) tick();
        fall_i = 1'b1;
        tick();
        fall_i = 1'b0;
        check("rr_valid", 32'(out_valid), 1);
        check("rr_width", 32'(out_width), 4);
        tick();
        check("rr_single", 32'(out_valid), 0);
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        check("rr_err_clr", 32'(err_o), 0);

        // rise+fall together in IDLE: error, no measurement; set beats clear
        rise_i = 1'b1;
        fall_i = 1'b1;
        tick();
        check("idle_rf_err",  32'(err_o), 1);
        check("idle_rf_busy", 32'(busy_o), 0);
        check("idle_rf_valid", 32'(out_valid), 0);
        clr_i = 1'b1;
        tick();
        rise_i = 1'b0;
        fall_i = 1'b0;
        check("set_wins_err", 32'(err_o), 1);
        tick();
        clr_i = 1'b0;
        check("err_clr2", 32'(err_o), 0);

        // rise+fall together in MEASURE: record pushed, measurement continues
        rise_i = 1'b1;
        tick();
        rise_i = 1'b0;
        repeat (2) tick();
        rise_i = 1'b1;
        fall_i = 1'b1;
        tick();
        rise_i = 1'b0;
        fall_i = 1'b0;
        check("mrf_valid", 32'(out_valid), 1);
        check("mrf_width", 32'(out_width), 3);
        check("mrf_busy",  32'(busy_o), 1);
        check("mrf_err",   32'(err_o), 0);
        repeat (3) tick();
        fall_i = 1'b1;
        tick();
        fall_i = 1'b0;
        check("mrf_width2", 32'(out_width), 4);
        check("mrf_err2",   32'(err_o), 0);
        tick();

        // reset mid-measure discards the pulse
        rise_i = 1'b1;
        tick();
        rise_i = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rmm_busy", 32'(busy_o), 0);
        fall_i = 1'b1;
        tick();
        fall_i = 1'b0;
        check("rmm_valid",   32'(out_valid), 0);
        check("rmm_width",   32'(out_width), 0);
        check("rmm_overrun", 32'(overrun_o), 0);
        check("rmm_err",     32'(err_o), 0);
        pulse(5);
        check("rmm_next_valid", 32'(out_valid), 1);
        check("rmm_next_width", 32'(out_width), 5);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pulse_width_meter.md
# pulse_width_meter

Downstream consumer of the both-edge detector stage. Takes the detector's one-cycle rise/fall event pulses, measures each high interval in `clk` cycles, and delivers one record per completed pulse over a valid/ready interface. Records go through a 2-entry FIFO, so a slow consumer does not stall measurement. Protocol faults are flagged in sticky status bits.

## Interface

Parameters:
- `WIDTH`, default 16: width counter width; maximum reportable width is 2^WIDTH−1.

Ports:
- `clk`  input  1  single clock; all logic on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `rise_i`  input  1  one-cycle pulse: monitored signal rose.
- `fall_i`  input  1  one-cycle pulse: monitored signal fell.
- `clr_i`  input  1  clears the sticky `overrun_o` and `err_o` bits.
- `out_valid`  output  1  FIFO head record is valid.
- `out_ready`  input  1  consumer accepts the head record.
- `out_width`  output  WIDTH  measured high width in cycles (head record).
- `out_sat`  output  1  head record's width saturated.
- `busy_o`  output  1  FSM is in MEASURE.
- `overrun_o`  output  1  sticky: a record was dropped because the FIFO was full.
- `err_o`  output  1  sticky: protocol fault (rise while measuring, or rise and fall together while IDLE).

## Operation

- FSM states: IDLE, MEASURE.
- **IDLE**
  - `rise_i` alone: go to MEASURE, `cnt`←1, `sat`←0.
  - `fall_i` alone: ignored.
  - `rise_i` and `fall_i` together: ignored; set `err_o`.
- **MEASURE**, no event: `cnt`←`cnt`+1, saturating at 2^WIDTH−1. Set `sat` when an increment is attempted at max.
- **MEASURE**, `fall_i` alone: push {`cnt`, `sat`}; go to IDLE.
- **MEASURE**, `rise_i` alone: previous pulse is lost (no record). Restart with `cnt`←1, `sat`←0; set `err_o`.
- **MEASURE**, `rise_i` and `fall_i` together: this is a fall followed by a new rise. Push {`cnt`, `sat`}, restart with `cnt`←1, stay in MEASURE. No error.
- **FIFO**: 2 entries. Pop when `out_valid && out_ready`.
  - Push into a full FIFO is dropped and sets `overrun_o`.
  - Push and pop in the same cycle on a full FIFO: the pop frees space first, so the push is accepted.
- `out_width`/`out_sat` show the head entry. They are 0 when the FIFO is empty. Once `out_valid` is asserted, they stay stable until popped.
- `clr_i`: clears both sticky bits. If a new error or overrun occurs in the same cycle, set wins.
- Arithmetic: the reported width equals the number of cycles from the rise-event cycle to the fall-event cycle. Rise sampled at cycle t and fall sampled at cycle t+N gives width N, with N ≥ 1.

## Timing

- **Reset** (synchronous, on `rst`=1 at a rising edge):
  - FSM goes to IDLE; FIFO is emptied.
  - `cnt`=0, `sat`=0.
  - `out_valid`=0, `out_width`=0, `out_sat`=0, `busy_o`=0, `overrun_o`=0, `err_o`=0.
- Reset during MEASURE discards the pulse in progress; no record is produced.
- `rst` overrides all inputs in the same cycle.
- `busy_o` rises the cycle after the rise is sampled and falls the cycle after the fall is sampled.
- **Latency**: `out_valid` asserts the cycle after the fall is sampled, if the FIFO was empty.
- **Throughput**: one record per cycle, sustained with `out_ready` held at 1.
- The consumer may hold `out_ready` high continuously. Valid does not depend combinationally on ready.

## Test plan

- **Basic width**: rise at cycle 10, fall at cycle 22, `out_ready`=1 → one record, `out_width`=12, `out_sat`=0, `out_valid` high at cycle 23 only.
- **Saturation** (`WIDTH`=4): rise, then fall 20 cycles later → `out_width`=15, `out_sat`=1.
- **Backpressure/overrun**: three pulses of widths 3, 5, 7 with `out_ready`=0 → FIFO holds 3 and 5, `overrun_o`=1. After raising `out_ready`: records 3 then 5, then `out_valid`=0. `clr_i` pulse → `overrun_o`=0.
- **Full push+pop**: FIFO full (4, 6) and `out_ready`=1 in the same cycle a width-2 fall arrives → no overrun; records delivered in order 4, 6, 2.
- **Protocol faults**:
  - Rise at cycle 0, rise at cycle 5, fall at cycle 9 → single record `out_width`=4, `err_o`=1.
  - Simultaneous rise/fall in MEASURE → record pushed, measurement continues, `err_o` unchanged.
- **Reset mid-measure**: rise, `rst` asserted 3 cycles later, then fall → no record. All outputs 0 after reset; the next clean pulse of width 5 reports 5.
